// File: rtl/rv5stage_pkg.sv
// Shared core constants and the writeback-source tag used by the writeback stage.
// Pure declarations; no logic.
package rv5stage_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;

    typedef enum logic [1:0] {
        WB_NONE,
        WB_ALU,
        WB_LSU
    } wb_src_e;
endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback-stage bundle: ALU/LSU request handshakes, decode reservations, register-file write port
// and busy scoreboard. Producers drive through master; the arbiter sits on slave.
interface wb_arbiter_if;
    import rv5stage_pkg::*;

    logic                  alu_valid;
    logic [REG_ADDR_W-1:0] alu_rd;
    logic [XLEN-1:0]       alu_data;
    logic                  alu_ready;

    logic                  lsu_valid;
    logic [REG_ADDR_W-1:0] lsu_rd;
    logic [XLEN-1:0]       lsu_data;
    logic                  lsu_ready;

    logic                  issue_valid;
    logic [REG_ADDR_W-1:0] issue_rd;

    logic                  w_enable;
    logic [REG_ADDR_W-1:0] w_addr;
    logic [XLEN-1:0]       w_data;
    logic [NUM_REGS-1:0]   busy;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data,
        output issue_valid, issue_rd,
        input  alu_ready, lsu_ready,
        input  w_enable, w_addr, w_data, busy
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        input  issue_valid, issue_rd,
        output alu_ready, lsu_ready,
        output w_enable, w_addr, w_data, busy
    );
endinterface

// File: rtl/wb_scoreboard.sv
// Pending-write tracker: one busy bit per register, set on issue, cleared on writeback, updated at
// the clock edge; a same-edge set wins over clear and register 0 never reads busy.
module wb_scoreboard
    import rv5stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_vld,
    input  logic [REG_ADDR_W-1:0] set_rd,
    input  logic                  clr_vld,
    input  logic [REG_ADDR_W-1:0] clr_rd,
    output logic [NUM_REGS-1:0]   busy
);
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;
    logic [NUM_REGS-1:0] busy_nxt;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_vld && (set_rd != '0)) set_mask[set_rd] = 1'b1;
        if (clr_vld && (clr_rd != '0)) clr_mask[clr_rd] = 1'b1;
        busy_nxt    = (busy & ~clr_mask) | set_mask;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) busy <= '0;
        else      busy <= busy_nxt;
    end
endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: LSU wins by default, ALU is force-granted after STARVE_LIMIT denied cycles;
// one-cycle registered write port, readies are combinational and held low during reset.
module wb_arbiter
    import rv5stage_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    wb_arbiter_if.slave   bus
);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0]      starve_cnt;
    logic [CNT_W-1:0]      starve_cnt_nxt;
    logic                  forced;
    logic                  alu_grant;
    logic                  lsu_grant;
    wb_src_e               src;
    logic                  xfer;
    logic [REG_ADDR_W-1:0] xfer_rd;
    logic [XLEN-1:0]       xfer_data;

    always_comb begin
        forced    = (starve_cnt == LIMIT_C);
        alu_grant = rst && (forced || !bus.lsu_valid);
        lsu_grant = rst && !forced;

        src = WB_NONE;
        if (bus.alu_valid && alu_grant)      src = WB_ALU;
        else if (bus.lsu_valid && lsu_grant) src = WB_LSU;

        xfer_rd   = '0;
        xfer_data = '0;
        case (src)
            WB_ALU:  begin xfer_rd = bus.alu_rd; xfer_data = bus.alu_data; end
            WB_LSU:  begin xfer_rd = bus.lsu_rd; xfer_data = bus.lsu_data; end
            default: begin xfer_rd = '0;         xfer_data = '0;           end
        endcase
        xfer = (src != WB_NONE);

        // Counter saturates at the limit on its own: forcing suppresses the increment.
        starve_cnt_nxt = starve_cnt;
        if (!bus.alu_valid || (src == WB_ALU))     starve_cnt_nxt = '0;
        else if (bus.lsu_valid && !forced)         starve_cnt_nxt = starve_cnt + CNT_W'(1);
    end

    assign bus.alu_ready = alu_grant;
    assign bus.lsu_ready = lsu_grant;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) starve_cnt <= '0;
        else      starve_cnt <= starve_cnt_nxt;
    end

    // Writes to x0 are accepted upstream but never reach the register file.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.w_enable <= 1'b0;
            bus.w_addr   <= '0;
            bus.w_data   <= '0;
        end else begin
            bus.w_enable <= xfer && (xfer_rd != '0);
            if (xfer && (xfer_rd != '0)) begin
                bus.w_addr <= xfer_rd;
                bus.w_data <= xfer_data;
            end
        end
    end

    wb_scoreboard u_scoreboard (
        .clk     (clk),
        .rst     (rst),
        .set_vld (bus.issue_valid),
        .set_rd  (bus.issue_rd),
        .clr_vld (xfer),
        .clr_rd  (xfer_rd),
        .busy    (bus.busy)
    );
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: stimulus queues expected register-file writes, a monitor pops
// and compares them whenever w_enable is seen; readies and busy are compared against constants.
module tb_wb_arbiter;
    logic clk;
    logic rst;
    int   checks;
    int   passed;
    logic [36:0] exp_q[$];
    logic [36:0] e;

    wb_arbiter_if bus();

    wb_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [4:0] addr, input logic [31:0] data);
        exp_q.push_back({addr, data});
    endtask

    // Monitor: every visible write must match the oldest queued expectation.
    always @(posedge clk) begin
        #1;
        if (rst && bus.w_enable) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_write: got addr %0d data 0x%0h, expected no write",
                         bus.w_addr, bus.w_data);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(bus.w_addr), 32'(e[36:32]));
                chk("wr_data", bus.w_data, e[31:0]);
            end
        end
    end

    initial begin
        checks = 0;
        passed = 0;
        rst = 1'b0;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_data = 32'h1;
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd2; bus.lsu_data = 32'h2;
        bus.issue_valid = 1'b0; bus.issue_rd = 5'd0;

        #2;
        chk("rst_alu_ready", 32'(bus.alu_ready), 32'd0);
        chk("rst_lsu_ready", 32'(bus.lsu_ready), 32'd0);
        chk("rst_w_enable",  32'(bus.w_enable),  32'd0);
        chk("rst_w_addr",    32'(bus.w_addr),    32'd0);
        chk("rst_w_data",    bus.w_data,         32'd0);
        chk("rst_busy",      bus.busy,           32'd0);
        bus.alu_valid = 1'b0;
        bus.lsu_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        step();

        // Lone ALU request
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF;
        #1;
        chk("alu_only_alu_ready", 32'(bus.alu_ready), 32'd1);
        chk("alu_only_lsu_ready", 32'(bus.lsu_ready), 32'd1);
        expect_wr(5'd5, 32'hDEADBEEF);
        step();
        bus.alu_valid = 1'b0;
        chk("alu_only_w_enable", 32'(bus.w_enable), 32'd1);

        // Starvation: four LSU wins, then the ALU is forced through
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd9; bus.alu_data = 32'hA9A9_0009;
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd7;
        for (int i = 0; i < 4; i++) begin
            bus.lsu_data = 32'h7000 + i;
            #1;
            chk("starve_alu_ready", 32'(bus.alu_ready), 32'd0);
            chk("starve_lsu_ready", 32'(bus.lsu_ready), 32'd1);
            expect_wr(5'd7, 32'h7000 + i);
            step();
        end
        #1;
        chk("forced_alu_ready", 32'(bus.alu_ready), 32'd1);
        chk("forced_lsu_ready", 32'(bus.lsu_ready), 32'd0);
        expect_wr(5'd9, 32'hA9A9_0009);
        step();
        bus.alu_rd = 5'd10; bus.alu_data = 32'hA10; bus.lsu_data = 32'h7777;
        #1;
        chk("post_force_alu_ready", 32'(bus.alu_ready), 32'd0);
        chk("post_force_lsu_ready", 32'(bus.lsu_ready), 32'd1);
        expect_wr(5'd7, 32'h7777);
        step();
        bus.lsu_valid = 1'b0;
        #1;
        chk("alu_after_lsu_ready", 32'(bus.alu_ready), 32'd1);
        expect_wr(5'd10, 32'hA10);
        step();
        bus.alu_valid = 1'b0;

        // Reserve then retire register 3
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd3;
        step();
        bus.issue_valid = 1'b0;
        chk("busy_set3", bus.busy, 32'h0000_0008);
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd3; bus.lsu_data = 32'h33;
        expect_wr(5'd3, 32'h33);
        step();
        bus.lsu_valid = 1'b0;
        chk("busy_clr3", bus.busy, 32'h0);
        chk("busy_clr3_w_enable", 32'(bus.w_enable), 32'd1);

        // Same-edge issue and writeback of register 3: set wins
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd3;
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd3; bus.lsu_data = 32'h44;
        expect_wr(5'd3, 32'h44);
        step();
        bus.issue_valid = 1'b0;
        bus.lsu_data = 32'h45;
        chk("set_over_clr_busy", bus.busy, 32'h0000_0008);
        chk("set_over_clr_addr", 32'(bus.w_addr), 32'd3);
        expect_wr(5'd3, 32'h45);
        step();
        bus.lsu_valid = 1'b0;
        chk("busy_cleanup", bus.busy, 32'h0);

        // Register 0 is never written and never busy
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'h1234;
        #1;
        chk("x0_alu_ready", 32'(bus.alu_ready), 32'd1);
        step();
        bus.alu_valid = 1'b0;
        chk("x0_w_enable", 32'(bus.w_enable), 32'd0);
        chk("x0_busy", bus.busy, 32'h0);
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd0;
        step();
        bus.issue_valid = 1'b0;
        chk("x0_issue_busy", bus.busy, 32'h0);

        // Reset in the middle of traffic
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd3;
        step();
        bus.issue_rd = 5'd7;
        step();
        bus.issue_valid = 1'b0;
        chk("busy_88", bus.busy, 32'h0000_0088);
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd12; bus.lsu_data = 32'h55;
        expect_wr(5'd12, 32'h55);
        step();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd13; bus.alu_data = 32'h66;
        bus.lsu_rd = 5'd14; bus.lsu_data = 32'h77;
        chk("pre_rst_w_enable", 32'(bus.w_enable), 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_w_enable",  32'(bus.w_enable),  32'd0);
        chk("mid_rst_w_addr",    32'(bus.w_addr),    32'd0);
        chk("mid_rst_busy",      bus.busy,           32'h0);
        chk("mid_rst_alu_ready", 32'(bus.alu_ready), 32'd0);
        chk("mid_rst_lsu_ready", 32'(bus.lsu_ready), 32'd0);
        bus.alu_valid = 1'b0;
        bus.lsu_valid = 1'b0;
        step();
        @(negedge clk);
        rst = 1'b1;
        step();

        // Arbitration resumes; the requests dropped by reset are not replayed
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd4; bus.lsu_data = 32'h88;
        #1;
        chk("resume_lsu_ready", 32'(bus.lsu_ready), 32'd1);
        expect_wr(5'd4, 32'h88);
        step();
        bus.lsu_valid = 1'b0;
        step();
        step();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
